shift_xfer_ctrl: RTL and testbench
==================================

// Module: shift_xfer_ctrl
// PURPOSE
//   Sequences one external shift_register_8bit instance for word-wide serial exchange.
//   - Accepts a TX word on a valid/ready handshake.
//   - Drives the word out on ser_out, MSB first, at one bit per DIV clocks.
//   - Samples ser_in at the end of each bit and shifts it into the register via sr_shift_en/sr_serial_in.
//   - After WIDTH bits, returns sr_parallel_out as the RX word on a valid/ready handshake.
//   Sits between a host (CPU/FIFO) and the serial line pins.
// PARAMETERS
//   WIDTH  8  bits per transfer; must equal the width of the attached shift register
//   DIV    4  clocks per bit period; legal range DIV >= 2
// PORTS
//   clk              input   1      system clock, rising edge
//   rst_n            input   1      asynchronous active-low reset
//   tx_data          input   WIDTH  word to transmit
//   tx_valid         input   1      tx_data is valid
//   tx_ready         output  1      controller can accept a word
//   rx_data          output  WIDTH  received word
//   rx_valid         output  1      rx_data is valid
//   rx_ready         input   1      host consumes rx_data
//   ser_out          output  1      serial line out
//   ser_in           input   1      serial line in
//   sr_shift_en      output  1      one-clock shift strobe to the shift register
//   sr_serial_in     output  1      bit to shift in; valid while sr_shift_en = 1
//   sr_parallel_out  input   WIDTH  contents of the shift register
//   busy             output  1      high in every state except IDLE
// BEHAVIOUR
//   Reset (async, rst_n = 0): state = IDLE.
//     Cleared to 0: tx_ready, rx_valid, rx_data, ser_out, sr_shift_en, sr_serial_in, busy, bit_cnt, div_cnt.
//     tx_ready returns to 1 on the first clock after reset release.
//     Reset mid-transfer aborts the transfer. No rx_valid is produced for it.
//   All outputs are registered.
//   FSM states: IDLE -> SHIFT -> SETTLE -> DONE -> IDLE.
//   IDLE:
//     - tx_ready = 1, ser_out = 0.
//     - tx_valid & tx_ready at edge E0: latch tx_data into tx_sh, bit_cnt = 0, div_cnt = 0, go to SHIFT.
//     - tx_ready drops in the cycle after E0.
//   SHIFT:
//     - ser_out = tx_sh[WIDTH-1] from the cycle after E0.
//     - Each bit holds for exactly DIV cycles. div_cnt counts 0..DIV-1.
//     - At div_cnt = DIV-1, on the same edge:
//       - Register sr_serial_in <= ser_in and sr_shift_en <= 1 (high for exactly one cycle).
//       - tx_sh shifts left by 1. bit_cnt increments. div_cnt wraps to 0.
//     - When bit_cnt reaches WIDTH at that edge, go to SETTLE.
//       ser_out returns to 0 in SETTLE.
//   SETTLE:
//     - One cycle. The final sr_shift_en pulse is visible here, and the shift register updates at its end.
//   DONE:
//     - Entered one cycle after SETTLE. On entry, rx_data <= sr_parallel_out.
//     - rx_valid = 1 from the cycle after that capture.
//     - rx_data and rx_valid hold until rx_valid & rx_ready.
//     - At that handshake edge: rx_valid <= 0, go to IDLE.
//     - tx_ready = 1 in the cycle after the handshake.
//   Latency (DIV = 4, WIDTH = 8):
//     - Bits occupy cycles 1..32.
//     - Shift pulses appear in cycles 5, 9, ..., 33.
//     - rx_valid first high in cycle 35.
//   Handshake rules:
//     - tx_valid while busy is ignored; no word is accepted and there is no side effect.
//     - rx_ready outside DONE is ignored.
//     - rx_ready already high at DONE entry gives a 1-cycle rx_valid pulse.
//   Counters: bit_cnt is clog2(WIDTH+1) bits and never wraps. div_cnt is clog2(DIV) bits.
//   sr_shift_en never asserts outside SHIFT/SETTLE. Total pulses per transfer = WIDTH exactly.
// TESTING
//   1. Reset checks:
//      - Hold rst_n = 0 for 3 clocks -> all outputs 0.
//      - Release -> tx_ready = 1 next cycle.
//      - Drop rst_n at cycle 12 of a transfer -> outputs 0 immediately; no rx_valid ever.
//   2. Loopback, ser_in tied to ser_out, DIV = 4:
//      - Send tx 8'hA5 -> ser_out sequence 1,0,1,0,0,1,0,1, each bit 4 cycles.
//      - 8 sr_shift_en pulses in cycles 5..33.
//      - rx_data = 8'hA5 with rx_valid in cycle 35.
//   3. Backpressure: rx_ready = 0 for 10 cycles after rx_valid -> rx_data stable, tx_ready = 0.
//      - tx_valid pulses during this time are not accepted.
//   4. Stuck-at line inputs:
//      - ser_in = 1 constant, tx 8'h00 -> rx_data = 8'hFF.
//      - ser_in = 0 constant, tx 8'hFF -> rx_data = 8'h00.
//   5. Back-to-back transfers:
//      - tx_valid held high, rx_ready held high, tx 8'h3C then 8'hC3.
//      - Second accept occurs 1 cycle after the first rx handshake.
//      - Loopback rx values are 8'h3C, then 8'hC3.
//   6. DIV = 2, WIDTH = 8: tx 8'h81 loopback -> each bit 2 cycles, rx_data = 8'h81 in cycle 19.

Source files
------------

// File: rtl/shift_xfer_ctrl.sv
// Word-wide serial exchange sequencer for an external shift register.
// Sends a TX word MSB first on ser_out and returns the shifted-in word as RX.
module shift_xfer_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             ser_out,
    input  logic             ser_in,
    output logic             sr_shift_en,
    output logic             sr_serial_in,
    input  logic [WIDTH-1:0] sr_parallel_out,
    output logic             busy
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        SETTLE,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]    div_cnt_q, div_cnt_d;
    logic             tx_ready_q, tx_ready_d;
    logic             rx_valid_q, rx_valid_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             ser_out_q, ser_out_d;
    logic             shift_en_q, shift_en_d;
    logic             serial_in_q, serial_in_d;
    logic             busy_q, busy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tx_sh_q     <= '0;
            bit_cnt_q   <= '0;
            div_cnt_q   <= '0;
            tx_ready_q  <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            ser_out_q   <= 1'b0;
            shift_en_q  <= 1'b0;
            serial_in_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_sh_q     <= tx_sh_d;
            bit_cnt_q   <= bit_cnt_d;
            div_cnt_q   <= div_cnt_d;
            tx_ready_q  <= tx_ready_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            ser_out_q   <= ser_out_d;
            shift_en_q  <= shift_en_d;
            serial_in_q <= serial_in_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tx_sh_d     = tx_sh_q;
        bit_cnt_d   = bit_cnt_q;
        div_cnt_d   = div_cnt_q;
        tx_ready_d  = tx_ready_q;
        rx_valid_d  = rx_valid_q;
        rx_data_d   = rx_data_q;
        ser_out_d   = ser_out_q;
        shift_en_d  = 1'b0;
        serial_in_d = serial_in_q;

        case (state_q)
            IDLE: begin
                tx_ready_d = 1'b1;
                ser_out_d  = 1'b0;
                if (tx_valid && tx_ready_q) begin
                    tx_sh_d    = tx_data;
                    bit_cnt_d  = '0;
                    div_cnt_d  = '0;
                    tx_ready_d = 1'b0;
                    ser_out_d  = tx_data[WIDTH-1];
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    // Bit period ends: sample the line and strobe the register.
                    div_cnt_d   = '0;
                    serial_in_d = ser_in;
                    shift_en_d  = 1'b1;
                    tx_sh_d     = tx_sh_q << 1;
                    bit_cnt_d   = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == BIT_LAST) begin
                        ser_out_d = 1'b0;
                        state_d   = SETTLE;
                    end else begin
                        ser_out_d = tx_sh_d[WIDTH-1];
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DW'(1);
                end
            end
            SETTLE: begin
                state_d = DONE;
            end
            DONE: begin
                // First DONE cycle sees the register after the final shift.
                if (!rx_valid_q) begin
                    rx_data_d  = sr_parallel_out;
                    rx_valid_d = 1'b1;
                end else if (rx_ready) begin
                    rx_valid_d = 1'b0;
                    tx_ready_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign tx_ready     = tx_ready_q;
    assign rx_valid     = rx_valid_q;
    assign rx_data      = rx_data_q;
    assign ser_out      = ser_out_q;
    assign sr_shift_en  = shift_en_q;
    assign sr_serial_in = serial_in_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_shift_xfer_ctrl.sv
// Directed bench for shift_xfer_ctrl with DIV=4 and DIV=2 instances,
// each attached to a behavioural 8-bit shift register.
module tb_shift_xfer_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid4 = 1'b0;
    logic       tx_valid2 = 1'b0;
    logic       rx_ready = 1'b0;
    logic [1:0] line_mode = 2'd0;

    logic       tx_ready4, rx_valid4, ser_out4, ser_in4, sr_shift_en4, sr_serial_in4, busy4;
    logic [7:0] rx_data4, sr4;
    logic       tx_ready2, rx_valid2, ser_out2, ser_in2, sr_shift_en2, sr_serial_in2, busy2;
    logic [7:0] rx_data2, sr2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // line_mode: 0 loopback, 1 stuck at 0, 2 stuck at 1
    assign ser_in4 = (line_mode == 2'd0) ? ser_out4 : line_mode[1];
    assign ser_in2 = (line_mode == 2'd0) ? ser_out2 : line_mode[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr4 <= 8'h00;
            sr2 <= 8'h00;
        end else begin
            if (sr_shift_en4) sr4 <= {sr4[6:0], sr_serial_in4};
            if (sr_shift_en2) sr2 <= {sr2[6:0], sr_serial_in2};
        end
    end

    shift_xfer_ctrl #(.WIDTH(8), .DIV(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .tx_data(tx_data), .tx_valid(tx_valid4), .tx_ready(tx_ready4),
        .rx_data(rx_data4), .rx_valid(rx_valid4), .rx_ready(rx_ready),
        .ser_out(ser_out4), .ser_in(ser_in4),
        .sr_shift_en(sr_shift_en4), .sr_serial_in(sr_serial_in4),
        .sr_parallel_out(sr4), .busy(busy4)
    );

    shift_xfer_ctrl #(.WIDTH(8), .DIV(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .tx_data(tx_data), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
        .rx_data(rx_data2), .rx_valid(rx_valid2), .rx_ready(rx_ready),
        .ser_out(ser_out2), .ser_in(ser_in2),
        .sr_shift_en(sr_shift_en2), .sr_serial_in(sr_serial_in2),
        .sr_parallel_out(sr2), .busy(busy2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_ready"}, tx_ready4, 0);
        check({tag, "_rx_valid"}, rx_valid4, 0);
        check({tag, "_rx_data"}, rx_data4, 0);
        check({tag, "_ser_out"}, ser_out4, 0);
        check({tag, "_shift_en"}, sr_shift_en4, 0);
        check({tag, "_serial_in"}, sr_serial_in4, 0);
        check({tag, "_busy"}, busy4, 0);
    endtask

    // One transfer with the given instance; lat is the cycle (1 = cycle after accept) rx_valid is seen.
    task automatic xfer(input bit sel, input logic [7:0] d, output logic [7:0] rxd, output int lat);
        int pulses;
        int w;
        rxd = 8'h00;
        lat = 0;
        pulses = 0;
        w = 0;
        while (!(sel ? tx_ready2 : tx_ready4) && w < 50) begin
            @(negedge clk);
            w++;
        end
        tx_data = d;
        if (sel) tx_valid2 = 1'b1;
        else     tx_valid4 = 1'b1;
        @(negedge clk);
        tx_valid2 = 1'b0;
        tx_valid4 = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (sel ? sr_shift_en2 : sr_shift_en4) pulses++;
            if (sel ? rx_valid2 : rx_valid4) begin
                lat = c;
                rxd = sel ? rx_data2 : rx_data4;
                break;
            end
            @(negedge clk);
        end
        check("xfer_pulses", pulses, 8);
        if (lat != 0) begin
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] a5;
        logic [7:0] rxd;
        int         lat;
        int         npulse;
        bit         seen;
        int         acc_t[2];
        int         rx_t[2];
        logic [7:0] rxv[2];
        int         n_acc;
        int         n_rx;

        // Reset held for 3 clocks
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        rst_n = 1'b1;
        #1;
        check("rel_tx_ready_pre", tx_ready4, 0);
        @(negedge clk);
        check("rel_tx_ready", tx_ready4, 1);
        check("rel_busy", busy4, 0);

        // Loopback A5 with DIV=4
        a5 = 8'hA5;
        line_mode = 2'd0;
        npulse = 0;
        tx_data = a5;
        tx_valid4 = 1'b1;
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk);
            if (c == 1) begin
                tx_valid4 = 1'b0;
                check("acc_busy", busy4, 1);
            end
            if (c == 2) check("acc_tx_ready", tx_ready4, 0);
            if (c <= 33) check("ser_out", ser_out4, (c <= 32) ? a5[7 - (c - 1) / 4] : 1'b0);
            if (c <= 34) check("shift_en", sr_shift_en4, (c >= 5 && c <= 33 && (c % 4) == 1) ? 1 : 0);
            if (sr_shift_en4) npulse++;
            if (c == 34) check("rx_valid_c34", rx_valid4, 0);
        end
        check("pulse_count", npulse, 8);
        check("rx_valid_c35", rx_valid4, 1);
        check("rx_data_a5", rx_data4, 8'hA5);

        // Backpressure for 10 cycles with ignored tx_valid pulses
        for (int k = 0; k < 10; k++) begin
            tx_data = 8'h5A;
            tx_valid4 = k[0];
            @(negedge clk);
            check("bp_rx_data", rx_data4, 8'hA5);
            check("bp_rx_valid", rx_valid4, 1);
            check("bp_tx_ready", tx_ready4, 0);
        end
        tx_valid4 = 1'b0;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("hs_rx_valid", rx_valid4, 0);
        check("hs_tx_ready", tx_ready4, 1);
        check("hs_busy", busy4, 0);

        // Reset dropped at cycle 12 of a transfer
        tx_data = 8'h3C;
        tx_valid4 = 1'b1;
        @(negedge clk);
        tx_valid4 = 1'b0;
        repeat (11) @(negedge clk);
        check("mid_busy_before", busy4, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (rx_valid4) seen = 1'b1;
        end
        check("midrst_no_rx", seen, 0);
        check("midrst_tx_ready", tx_ready4, 1);

        // Stuck-at line inputs
        line_mode = 2'd2;
        xfer(1'b0, 8'h00, rxd, lat);
        check("stuck1_rx", rxd, 8'hFF);
        check("stuck1_lat", lat, 35);
        line_mode = 2'd1;
        xfer(1'b0, 8'hFF, rxd, lat);
        check("stuck0_rx", rxd, 8'h00);
        check("stuck0_lat", lat, 35);
        line_mode = 2'd0;

        // Back-to-back with tx_valid and rx_ready held high
        @(negedge clk);
        n_acc = 0;
        n_rx = 0;
        acc_t = '{0, 0};
        rx_t = '{0, 0};
        rxv = '{8'h00, 8'h00};
        tx_data = 8'h3C;
        tx_valid4 = 1'b1;
        rx_ready = 1'b1;
        for (int t = 0; t < 200 && n_rx < 2; t++) begin
            if (tx_valid4 && tx_ready4 && n_acc < 2) begin
                acc_t[n_acc] = t;
                n_acc++;
            end
            if (rx_valid4) begin
                rx_t[n_rx] = t;
                rxv[n_rx] = rx_data4;
                n_rx++;
                if (n_rx == 1) tx_data = 8'hC3;
                else           tx_valid4 = 1'b0;
            end
            @(negedge clk);
        end
        tx_valid4 = 1'b0;
        rx_ready = 1'b0;
        check("b2b_n_rx", n_rx, 2);
        check("b2b_n_acc", n_acc, 2);
        check("b2b_rx0", rxv[0], 8'h3C);
        check("b2b_rx1", rxv[1], 8'hC3);
        check("b2b_lat0", rx_t[0] - acc_t[0], 35);
        check("b2b_gap", acc_t[1] - rx_t[0], 1);
        check("b2b_lat1", rx_t[1] - acc_t[1], 35);
        check("b2b_rx_pulse", rx_valid4, 0);

        // DIV=2 loopback
        xfer(1'b1, 8'h81, rxd, lat);
        check("div2_rx", rxd, 8'h81);
        check("div2_lat", lat, 19);
        check("div2_idle_tx_ready", tx_ready2, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
